pulse_frame_sequencer: RTL and testbench
========================================

Name: pulse_frame_sequencer

Overview:
- Per-frame timing sequencer that drives the fast-path control outputs: fast optical switch, second (Bob) intensity modulator gate, and scope trigger.
- Runs in the DAC clock domain. Generates programmable-offset, programmable-width pulses at a fixed frame period.
- Can start immediately or on a synchronous external frame sync, and runs for a programmed frame count or continuously.
- Software configures it through the system wrapper's register space; its outputs go straight to the J3 header pins.

Parameters:
- CTR_W, 16, width of frame period / offset / width / counter fields
- FCNT_W, 16, width of frame-count fields
- OUT_INV, 3'b000, per-channel output inversion mask {trig, im2, opsw}; set a bit where an inverting level translator sits downstream

Ports:
- clk  in  1  DAC-rate clock, the only clock
- rstn  in  1  asynchronous, active-low reset
- go  in  1  start pulse; accepted only in IDLE
- stop  in  1  abort pulse; honoured in any state
- sync_en  in  1  1: wait for frame_sync before the first frame; 0: start immediately
- frame_sync  in  1  external frame sync, synchronous to clk
- frame_pd  in  CTR_W  frame period in clk cycles; legal range ≥2
- frame_num  in  FCNT_W  frames to run; 0 means continuous
- ch_start  in  3*CTR_W  per-channel start offset within the frame; ch0=opsw, ch1=im2, ch2=trig
- ch_width  in  3*CTR_W  per-channel pulse width in cycles
- opsw_out  out  1  fast optical switch drive
- im2_out  out  1  second IM gate
- trig_out  out  1  scope trigger
- frame_start  out  1  one-cycle pulse at the start of each frame
- busy  out  1  high in WAIT_SYNC or RUN
- done  out  1  one-cycle pulse on normal completion
- cfg_err  out  1  sticky flag: go was issued with frame_pd<2; cleared by the next accepted go
- frames_done  out  FCNT_W  completed-frame count

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; all counters 0
  - busy, done, frame_start, cfg_err = 0
  - each channel output = its inactive level, i.e. its OUT_INV bit
- States: IDLE, WAIT_SYNC, RUN, DONE.
- IDLE:
  - go with frame_pd<2: set cfg_err, stay in IDLE.
  - Otherwise go latches frame_pd, frame_num, ch_start, ch_width and sync_en into shadow registers, clears frames_done and cfg_err, then:
    - goes to WAIT_SYNC if sync_en=1, else to RUN with fctr=0.
  - Input changes after go have no effect until the next go.
- WAIT_SYNC:
  - Rising edge of frame_sync (registered edge detect: current=1, previous=0) → RUN with fctr=0 on the next cycle.
  - A sync edge in the same cycle as go is ignored; the edge detector only runs in WAIT_SYNC.
- RUN:
  - fctr increments each cycle and wraps from frame_pd-1 to 0.
  - On the wrap, frames_done increments.
  - If frame_num≠0 and the incremented frames_done == frame_num → DONE.
  - frames_done saturates at all-ones in continuous mode.
- DONE:
  - Lasts one cycle: done=1, then → IDLE.
  - go arriving in DONE is ignored.
- stop:
  - In any non-IDLE state → IDLE next cycle.
  - Outputs return to inactive level next cycle; no done pulse; frames_done is held.
  - stop takes priority over go, frame wrap and completion in the same cycle.
- Channel window, active (pre-inversion) when ch_start ≤ fctr < ch_start+ch_width:
  - The sum is evaluated at CTR_W+1 bits, so there is no wrap-around.
  - The portion of a window beyond frame_pd-1 is truncated; it does not carry into the next frame.
  - ch_width=0 or ch_start ≥ frame_pd → channel never active.
- Output timing: registered; each output reflects the previous cycle's fctr, giving latency 1.
  - Output = active XOR OUT_INV[ch], and is forced inactive outside RUN.
- frame_start: registered, high for one cycle, one cycle after fctr==0 in RUN, so it aligns with channel outputs at offset 0.
- busy = (state==WAIT_SYNC || state==RUN), registered.

Test Plan:
- Reset, then go with frame_pd=10, frame_num=3, sync_en=0, opsw start=2 width=3 → opsw high at frame cycles 2..4 (3 cycles, latency 1) in each of 3 frames; frame_start fires 3 times; done pulses once, 30 cycles (+1 latency) after start; frames_done=3; busy then drops.
- sync_en=1, go, frame_sync held low for 50 cycles then rising → no outputs during the wait; frame_start occurs 2 cycles after the sync edge (1 cycle to enter RUN, 1 register).
- frame_pd=8, trig start=6 width=5 → trig high for 2 cycles per frame (truncated); im2 width=0 → never high; opsw start=9 → never high.
- frame_num=0 with stop asserted mid-frame at fctr=4 of frame 5 → outputs inactive the next cycle, no done pulse, frames_done=5, state IDLE; a subsequent go restarts from fctr=0.
- OUT_INV=3'b111 → all outputs 1 in reset and IDLE, and pulse low inside windows.
- go with frame_pd=1 → cfg_err=1, busy stays 0; then go with frame_pd=4 → cfg_err clears and the run proceeds; stop and go asserted in the same IDLE cycle → stays IDLE.

Source files
------------

// File: rtl/pulse_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pulse_frame_sequencer
// Brief    : Per-frame timing sequencer for the fast-path control outputs
//            (optical switch, second IM gate, scope trigger). Produces three
//            programmable offset/width pulses inside a fixed-period frame,
//            started immediately or on an external frame sync, for a fixed
//            frame count or continuously.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_frame_sequencer #(
    parameter int         CTR_W   = 16,
    parameter int         FCNT_W  = 16,
    parameter logic [2:0] OUT_INV = 3'b000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 go,
    input  logic                 stop,
    input  logic                 sync_en,
    input  logic                 frame_sync,
    input  logic [CTR_W-1:0]     frame_pd,
    input  logic [FCNT_W-1:0]    frame_num,
    input  logic [3*CTR_W-1:0]   ch_start,
    input  logic [3*CTR_W-1:0]   ch_width,
    output logic                 opsw_out,
    output logic                 im2_out,
    output logic                 trig_out,
    output logic                 frame_start,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [FCNT_W-1:0]    frames_done
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_SYNC = 2'd1;
    localparam logic [1:0] c_RUN       = 2'd2;
    localparam logic [1:0] c_DONE      = 2'd3;

    localparam logic [CTR_W-1:0] c_PD_MIN = CTR_W'(2);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    // Shadow copies of the run configuration, frozen at an accepted go
    logic [CTR_W-1:0]    r_pd;
    logic [FCNT_W-1:0]   r_num;
    logic [3*CTR_W-1:0]  r_start;
    logic [3*CTR_W-1:0]  r_width;

    logic [CTR_W-1:0]    r_fctr;
    logic [FCNT_W-1:0]   r_frames_done;
    logic                r_cfg_err;
    logic                r_fs_prev;

    logic [2:0]          r_out;
    logic                r_frame_start;
    logic                r_busy;
    logic                r_done;

    logic                w_go_ok;
    logic                w_go_bad;
    logic                w_sync_edge;
    logic                w_wrap;
    logic                w_last;
    logic                w_run_live;
    logic [FCNT_W-1:0]   w_fd_inc;
    logic [2:0]          w_act;

    // stop outranks go, so a go coincident with stop is not looked at at all
    assign w_go_ok     = go && !stop && (frame_pd >= c_PD_MIN);
    assign w_go_bad    = go && !stop && (frame_pd <  c_PD_MIN);
    assign w_sync_edge = frame_sync && !r_fs_prev;
    assign w_wrap      = (r_fctr == (r_pd - CTR_W'(1)));
    // Saturating increment keeps a continuous run from rolling the count over
    assign w_fd_inc    = (&r_frames_done) ? r_frames_done : (r_frames_done + FCNT_W'(1));
    assign w_last      = (r_num != '0) && (w_fd_inc == r_num);
    assign w_run_live  = (r_state == c_RUN) && !stop;

    // Window compare done one bit wider so start+width can never wrap; the
    // frame counter never exceeds frame_pd-1, which truncates long windows
    for (genvar k = 0; k < 3; k++) begin : g_ch
        logic [CTR_W:0] w_lo;
        logic [CTR_W:0] w_hi;
        logic [CTR_W:0] w_pos;
        assign w_lo     = {1'b0, r_start[k*CTR_W +: CTR_W]};
        assign w_hi     = w_lo + {1'b0, r_width[k*CTR_W +: CTR_W]};
        assign w_pos    = {1'b0, r_fctr};
        assign w_act[k] = (w_pos >= w_lo) && (w_pos < w_hi);
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_go_ok) begin
                    w_state_nxt = sync_en ? c_WAIT_SYNC : c_RUN;
                end
            end
            c_WAIT_SYNC: begin
                if (stop) begin
                    w_state_nxt = c_IDLE;
                end else if (w_sync_edge) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (stop) begin
                    w_state_nxt = c_IDLE;
                end else if (w_wrap && w_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Configuration capture, frame counter and completed-frame count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pd          <= '0;
            r_num         <= '0;
            r_start       <= '0;
            r_width       <= '0;
            r_fctr        <= '0;
            r_frames_done <= '0;
            r_cfg_err     <= 1'b0;
            r_fs_prev     <= 1'b0;
        end else begin
            r_fs_prev <= frame_sync;
            case (r_state)
                c_IDLE: begin
                    if (w_go_ok) begin
                        r_pd          <= frame_pd;
                        r_num         <= frame_num;
                        r_start       <= ch_start;
                        r_width       <= ch_width;
                        r_fctr        <= '0;
                        r_frames_done <= '0;
                        r_cfg_err     <= 1'b0;
                    end else if (w_go_bad) begin
                        r_cfg_err <= 1'b1;
                    end
                end
                c_RUN: begin
                    if (!stop) begin
                        r_fctr <= w_wrap ? '0 : (r_fctr + CTR_W'(1));
                        if (w_wrap) begin
                            r_frames_done <= w_fd_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs; channels idle at their inversion level outside RUN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out         <= OUT_INV;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_out         <= (w_act & {3{w_run_live}}) ^ OUT_INV;
            r_frame_start <= w_run_live && (r_fctr == '0);
            r_busy        <= (w_state_nxt == c_WAIT_SYNC) || (w_state_nxt == c_RUN);
            r_done        <= (w_state_nxt == c_DONE);
        end
    end

    assign opsw_out    = r_out[0];
    assign im2_out     = r_out[1];
    assign trig_out    = r_out[2];
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;
    assign frames_done = r_frames_done;

endmodule
`default_nettype wire

// File: tb/tb_pulse_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_frame_sequencer
// Brief    : Self-checking bench for pulse_frame_sequencer: directed scenario
//            table, hand-written corner sequences and randomized traffic
//            checked every cycle against a frame-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_frame_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        go, stop, sync_en, frame_sync;
    logic [15:0] frame_pd, frame_num;
    logic [47:0] ch_start, ch_width;

    logic        opsw_out, im2_out, trig_out, frame_start, busy, done, cfg_err;
    logic [15:0] frames_done;
    logic        i_opsw, i_im2, i_trig, i_fs, i_busy, i_done, i_cfg_err;
    logic [15:0] i_frames;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pulse_frame_sequencer #(.CTR_W(16), .FCNT_W(16), .OUT_INV(3'b000)) dut (
        .clk(clk), .rstn(rstn), .go(go), .stop(stop), .sync_en(sync_en),
        .frame_sync(frame_sync), .frame_pd(frame_pd), .frame_num(frame_num),
        .ch_start(ch_start), .ch_width(ch_width), .opsw_out(opsw_out),
        .im2_out(im2_out), .trig_out(trig_out), .frame_start(frame_start),
        .busy(busy), .done(done), .cfg_err(cfg_err), .frames_done(frames_done)
    );

    pulse_frame_sequencer #(.CTR_W(16), .FCNT_W(16), .OUT_INV(3'b111)) dut_inv (
        .clk(clk), .rstn(rstn), .go(go), .stop(stop), .sync_en(sync_en),
        .frame_sync(frame_sync), .frame_pd(frame_pd), .frame_num(frame_num),
        .ch_start(ch_start), .ch_width(ch_width), .opsw_out(i_opsw),
        .im2_out(i_im2), .trig_out(i_trig), .frame_start(i_fs),
        .busy(i_busy), .done(i_done), .cfg_err(i_cfg_err), .frames_done(i_frames)
    );

    // Reference model: a run is tracked as elapsed cycles t since it began;
    // frame position and completed frames fall out as t % pd and t / pd.
    // phase: 0 idle, 1 waiting for sync, 2 running, 3 completion cycle.
    typedef struct packed {
        int       phase;
        int       t;
        int       pd;
        int       num;
        int       st0, st1, st2;
        int       wd0, wd1, wd2;
        int       frames;
        bit       prev_sync;
        bit       cfg_err;
        bit [2:0] out;
        bit       fs;
        bit       busy;
        bit       done;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(mstate_t cur, bit go_i, bit stop_i, bit se_i, bit fs_i,
                                     int pd_i, int num_i, logic [47:0] st_i, logic [47:0] wd_i);
        mstate_t n;
        int      fc;
        int      fr;
        n           = cur;
        n.prev_sync = fs_i;
        n.out       = 3'b000;
        n.fs        = 1'b0;
        case (cur.phase)
            0: begin
                if (go_i && !stop_i) begin
                    if (pd_i < 2) begin
                        n.cfg_err = 1'b1;
                    end else begin
                        n.cfg_err = 1'b0;
                        n.pd  = pd_i;
                        n.num = num_i;
                        n.st0 = int'(st_i[15:0]);  n.st1 = int'(st_i[31:16]); n.st2 = int'(st_i[47:32]);
                        n.wd0 = int'(wd_i[15:0]);  n.wd1 = int'(wd_i[31:16]); n.wd2 = int'(wd_i[47:32]);
                        n.frames = 0;
                        n.t      = 0;
                        n.phase  = se_i ? 1 : 2;
                    end
                end
            end
            1: begin
                if (stop_i) n.phase = 0;
                else if (fs_i && !cur.prev_sync) begin
                    n.phase = 2;
                    n.t     = 0;
                end
            end
            2: begin
                if (stop_i) begin
                    n.phase = 0;
                end else begin
                    fc       = cur.t % cur.pd;
                    n.out[0] = (fc >= cur.st0) && (fc < cur.st0 + cur.wd0);
                    n.out[1] = (fc >= cur.st1) && (fc < cur.st1 + cur.wd1);
                    n.out[2] = (fc >= cur.st2) && (fc < cur.st2 + cur.wd2);
                    n.fs     = (fc == 0);
                    n.t      = cur.t + 1;
                    fr       = n.t / cur.pd;
                    n.frames = (fr > 65535) ? 65535 : fr;
                    if (cur.num != 0 && n.t == cur.num * cur.pd) n.phase = 3;
                end
            end
            default: n.phase = 0;
        endcase
        n.busy = (n.phase == 1) || (n.phase == 2);
        n.done = (n.phase == 3);
        return n;
    endfunction

    // Model advances on the same edge as the DUT, from the same inputs
    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '0;
        else m <= step(m, go, stop, sync_en, frame_sync, int'(frame_pd), int'(frame_num),
                       ch_start, ch_width);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_main",
                  64'({opsw_out, im2_out, trig_out, frame_start, busy, done, cfg_err, frames_done}),
                  64'({m.out[0], m.out[1], m.out[2], m.fs, m.busy, m.done, m.cfg_err, m.frames[15:0]}));
            check("cyc_inv",
                  64'({i_opsw, i_im2, i_trig, i_fs, i_busy, i_done, i_cfg_err, i_frames}),
                  64'({~m.out[0], ~m.out[1], ~m.out[2], m.fs, m.busy, m.done, m.cfg_err, m.frames[15:0]}));
        end
    end

    task automatic set_cfg(input int pd, input int num, input int s0, input int w0,
                           input int s1, input int w1, input int s2, input int w2);
        frame_pd  = 16'(pd);
        frame_num = 16'(num);
        ch_start  = {16'(s2), 16'(s1), 16'(s0)};
        ch_width  = {16'(w2), 16'(w1), 16'(w0)};
    endtask

    // Called at a falling edge; returns at the falling edge after go is taken
    task automatic pulse_go();
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
    endtask

    typedef struct {
        int pd, num, s0, w0, s1, w1, s2, w2;
        int e_opsw, e_im2, e_trig, e_fs, e_done_at, e_first_opsw;
    } tab_t;

    tab_t tab[4];

    initial begin
        int c_op, c_im, c_tr, c_fs, n_done, done_at, first_op, cnt;

        // pd num  s0 w0   s1 w1   s2 w2       opsw im2 trig fs done_at first_opsw
        tab[0] = '{10, 3,  2, 3,   0, 0,   0, 1,        9,  0,  3,  3, 30,  3};
        tab[1] = '{ 8, 2,  9, 2,   1, 0,   6, 5,        0,  0,  4,  2, 16, -1};
        tab[2] = '{ 2, 4,  0, 2,   1, 1,   1, 65535,    8,  4,  4,  4,  8,  1};
        tab[3] = '{ 5, 1,  4, 1,   0, 5,   3, 10,       1,  5,  2,  1,  5,  5};

        rstn = 1'b0; go = 1'b0; stop = 1'b0; sync_en = 1'b0; frame_sync = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_main", 64'({opsw_out, im2_out, trig_out, frame_start, busy, done, cfg_err, frames_done}), 64'(0));
        check("rst_inv_outs", 64'({i_opsw, i_im2, i_trig}), 64'(3'b111));
        rstn   = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Directed scenario table
        for (int s = 0; s < 4; s++) begin
            set_cfg(tab[s].pd, tab[s].num, tab[s].s0, tab[s].w0, tab[s].s1, tab[s].w1, tab[s].s2, tab[s].w2);
            sync_en = 1'b0;
            pulse_go();
            c_op = 0; c_im = 0; c_tr = 0; c_fs = 0; n_done = 0; done_at = -1; first_op = -1;
            for (int j = 0; j <= tab[s].pd * tab[s].num + 4; j++) begin
                if (j > 0) @(negedge clk);
                if (opsw_out) begin c_op++; if (first_op < 0) first_op = j; end
                if (im2_out) c_im++;
                if (trig_out) c_tr++;
                if (frame_start) c_fs++;
                if (done) begin n_done++; if (done_at < 0) done_at = j; end
            end
            check($sformatf("tab%0d_opsw_cnt", s), 64'(c_op), 64'(tab[s].e_opsw));
            check($sformatf("tab%0d_im2_cnt", s), 64'(c_im), 64'(tab[s].e_im2));
            check($sformatf("tab%0d_trig_cnt", s), 64'(c_tr), 64'(tab[s].e_trig));
            check($sformatf("tab%0d_fs_cnt", s), 64'(c_fs), 64'(tab[s].e_fs));
            check($sformatf("tab%0d_done_cnt", s), 64'(n_done), 64'(1));
            check($sformatf("tab%0d_done_at", s), 64'(done_at), 64'(tab[s].e_done_at));
            check($sformatf("tab%0d_first_opsw", s), 64'(first_op), 64'(tab[s].e_first_opsw));
            check($sformatf("tab%0d_frames", s), 64'(frames_done), 64'(tab[s].num));
            check($sformatf("tab%0d_busy_end", s), 64'(busy), 64'(0));
        end

        // Sync start: an edge coincident with go is ignored, then a long wait
        set_cfg(6, 1, 0, 1, 0, 0, 0, 0);
        sync_en = 1'b1; frame_sync = 1'b1;
        pulse_go();
        sync_en = 1'b0;
        cnt = 0;
        repeat (10) begin @(negedge clk); cnt += int'(frame_start); end
        check("sync_go_edge_busy", 64'(busy), 64'(1));
        check("sync_go_edge_fs", 64'(cnt), 64'(0));
        frame_sync = 1'b0;
        frame_pd   = 16'd3;
        cnt = 0;
        repeat (50) begin @(negedge clk); cnt += int'(opsw_out | im2_out | trig_out | frame_start); end
        check("sync_wait_quiet", 64'(cnt), 64'(0));
        check("sync_wait_busy", 64'(busy), 64'(1));
        frame_sync = 1'b1;
        @(negedge clk);
        check("sync_fs_plus1", 64'(frame_start), 64'(0));
        @(negedge clk);
        check("sync_fs_plus2", 64'({frame_start, opsw_out}), 64'(2'b11));
        frame_sync = 1'b0;
        repeat (8) @(negedge clk);
        check("sync_end_frames", 64'({busy, frames_done}), 64'(17'd1));

        // Continuous run aborted at fctr=4 of frame 5
        set_cfg(7, 0, 3, 3, 0, 0, 0, 0);
        pulse_go();
        repeat (39) @(negedge clk);
        check("stop_pre_opsw", 64'({opsw_out, busy}), 64'(2'b11));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_post", 64'({opsw_out, busy, done, frames_done}), 64'({3'b000, 16'd5}));
        n_done = 0;
        repeat (5) begin @(negedge clk); n_done += int'(done); end
        check("stop_no_done", 64'({n_done[3:0], frames_done}), 64'({4'd0, 16'd5}));
        frame_num = 16'd2;
        pulse_go();
        check("restart_clear", 64'({busy, frames_done}), 64'({1'b1, 16'd0}));
        @(negedge clk);
        check("restart_fs", 64'(frame_start), 64'(1));
        repeat (16) @(negedge clk);

        // Illegal period, recovery, and stop+go in IDLE
        set_cfg(1, 1, 0, 1, 0, 0, 0, 0);
        pulse_go();
        check("cfgerr_set", 64'({cfg_err, busy}), 64'(2'b10));
        repeat (3) @(negedge clk);
        check("cfgerr_sticky", 64'({cfg_err, busy}), 64'(2'b10));
        frame_pd = 16'd4;
        pulse_go();
        check("cfgerr_clear", 64'({cfg_err, busy}), 64'(2'b01));
        repeat (6) @(negedge clk);
        stop = 1'b1;
        pulse_go();
        stop = 1'b0;
        check("stop_go_idle", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        check("stop_go_idle_later", 64'(busy), 64'(0));

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            frame_pd   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom_range(2, 12));
            frame_num  = 16'($urandom_range(0, 3));
            for (int k = 0; k < 3; k++) begin
                ch_start[k*16 +: 16] = 16'($urandom_range(0, 13));
                ch_width[k*16 +: 16] = 16'($urandom_range(0, 8));
            end
            go         = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 59) == 0);
            sync_en    = 1'($urandom_range(0, 1));
            frame_sync = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        go = 1'b0; stop = 1'b0; frame_sync = 1'b0;
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
